tdpram_pipe_be: RTL and testbench

//   Single-clock true dual-port RAM, the parametrised successor to the plain TDP RAM wrapper.

---
 rtl/tdpram_pipe_be.sv | 89 ++++++++
 tb/tb_tdpram_pipe_be.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/tdpram_pipe_be.sv
// tdpram_pipe_be: true dual-port RAM with byte enables, read-during-write mode, output pipeline and collision flag
module tdpram_pipe_be #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_DEPTH  = 1024,
    parameter int OUT_DELAY  = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_en_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_we_a,
    input  logic [ADDR_WIDTH-1:0]            i_addr_a,
    input  logic [DATA_WIDTH-1:0]            i_data_a,
    output logic [DATA_WIDTH-1:0]            o_data_a,
    output logic                             o_valid_a,
    input  logic                             i_en_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_we_b,
    input  logic [ADDR_WIDTH-1:0]            i_addr_b,
    input  logic [DATA_WIDTH-1:0]            i_data_b,
    output logic [DATA_WIDTH-1:0]            o_data_b,
    output logic                             o_valid_b,
    output logic                             o_collision
);
    localparam int NB_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0]                 mem [RAM_DEPTH];
    logic [1:0]                            en, ok;
    logic [1:0][ADDR_WIDTH-1:0]            addr;
    logic [1:0][DATA_WIDTH-1:0]            din, q;
    logic [1:0][NB_BYTES-1:0]              we_raw, we;
    logic [DATA_WIDTH-1:0]                 d [2][OUT_DELAY];
    logic [1:0][OUT_DELAY-1:0]             v;
    logic                                  coll;

    // Index 0 is port A, index 1 is port B so both ports share one description
    assign en     = {i_en_b, i_en_a};
    assign addr   = {i_addr_b, i_addr_a};
    assign din    = {i_data_b, i_data_a};
    assign we_raw = {i_we_b, i_we_a};

    // Qualify writes by range and request; form the read word (old word, optionally merged with own write)
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ok[p] = 32'(addr[p]) < RAM_DEPTH;
            we[p] = we_raw[p] & {NB_BYTES{en[p] & ok[p]}};
            q[p]  = ok[p] ? mem[addr[p]] : '0;
            for (int i = 0; i < NB_BYTES; i++)
                if (RDW_MODE != 0 && we[p][i]) q[p][i*BYTE_WIDTH +: BYTE_WIDTH] = din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Byte-lane array writes, ignored during reset; port A is applied last so it owns lanes both ports enable
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (!i_rst) begin
            for (int p = 1; p >= 0; p--)
                for (int i = 0; i < NB_BYTES; i++)
                    if (we[p][i]) mem[addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Read pipeline with valid strobes; data stages only advance with valid so outputs hold between strobes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v    <= '0;
            coll <= 1'b0;
            for (int p = 0; p < 2; p++)
                for (int s = 0; s < OUT_DELAY; s++)
                    d[p][s] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int s = OUT_DELAY - 1; s > 0; s--) begin
                    v[p][s] <= v[p][s-1];
                    if (v[p][s-1]) d[p][s] <= d[p][s-1];
                end
                v[p][0] <= en[p];
                if (en[p]) d[p][0] <= q[p];
            end
            coll <= en[0] & en[1] & ok[0] & (addr[0] == addr[1]) & ((|we[0]) | (|we[1]));
        end
    end

    assign o_data_a    = d[0][OUT_DELAY-1];
    assign o_data_b    = d[1][OUT_DELAY-1];
    assign o_valid_a   = v[0][OUT_DELAY-1];
    assign o_valid_b   = v[1][OUT_DELAY-1];
    assign o_collision = coll;
endmodule

// File: tb/tb_tdpram_pipe_be.sv
// tb_tdpram_pipe_be: directed checks of two RAM configurations driven by shared stimulus
module tb_tdpram_pipe_be;
    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [3:0]  we_a, we_b;
    logic [9:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic [31:0] q0a, q0b, q1a, q1b;
    logic        v0a, v0b, c0, v1a, v1b, c1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    tdpram_pipe_be #(.RAM_DEPTH(1000), .OUT_DELAY(1), .RDW_MODE(0)) u0 (
        .i_clk(clk), .i_rst(rst),
        .i_en_a(en_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_data_a(data_a), .o_data_a(q0a), .o_valid_a(v0a),
        .i_en_b(en_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_data_b(data_b), .o_data_b(q0b), .o_valid_b(v0b),
        .o_collision(c0)
    );

    tdpram_pipe_be #(.RAM_DEPTH(1024), .OUT_DELAY(3), .RDW_MODE(1)) u1 (
        .i_clk(clk), .i_rst(rst),
        .i_en_a(en_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_data_a(data_a), .o_data_a(q1a), .o_valid_a(v1a),
        .i_en_b(en_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_data_b(data_b), .o_data_b(q1b), .o_valid_b(v1b),
        .o_collision(c1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pa(input logic e, input logic [3:0] w, input logic [9:0] ad, input logic [31:0] dt);
        en_a = e; we_a = w; addr_a = ad; data_a = dt;
    endtask

    task automatic pb(input logic e, input logic [3:0] w, input logic [9:0] ad, input logic [31:0] dt);
        en_b = e; we_b = w; addr_b = ad; data_b = dt;
    endtask

    task automatic idle();
        pa(1'b0, 4'h0, 10'd0, 32'h0);
        pb(1'b0, 4'h0, 10'd0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        chk("rst_q0a", q0a, 32'h0);
        chk("rst_v0a", 32'(v0a), 32'h0);
        chk("rst_v0b", 32'(v0b), 32'h0);
        chk("rst_c0", 32'(c0), 32'h0);
        chk("rst_v1a", 32'(v1a), 32'h0);
        chk("rst_q1b", q1b, 32'h0);
        rst = 1'b0;
        // write then cross-port read on the next edge
        pa(1'b1, 4'hF, 10'h010, 32'hDEADBEEF); step();
        pb(1'b1, 4'h0, 10'h010, 32'h0); step();
        chk("t1_v0b", 32'(v0b), 32'h1);
        chk("t1_q0b", q0b, 32'hDEADBEEF);
        step();
        chk("t1_hold_v0b", 32'(v0b), 32'h0);
        chk("t1_hold_q0b", q0b, 32'hDEADBEEF);
        step(); step();
        // byte enables
        pa(1'b1, 4'hF, 10'd5, 32'h11223344); step();
        pa(1'b1, 4'b0101, 10'd5, 32'hAABBCCDD); step();
        chk("t2_rdw0_q0a", q0a, 32'h11223344);
        pb(1'b1, 4'h0, 10'd5, 32'h0); step();
        chk("t2_q0b", q0b, 32'h11BB33DD);
        step();
        chk("t2_rdw1_q1a", q1a, 32'h11BB33DD);
        chk("t2_rdw1_v1a", 32'(v1a), 32'h1);
        step();
        chk("t2_q1b", q1b, 32'h11BB33DD);
        chk("t2_v1b", 32'(v1b), 32'h1);
        chk("t2_v1a_idle", 32'(v1a), 32'h0);
        // read-during-write modes
        pa(1'b1, 4'hF, 10'd7, 32'h1); step();
        pa(1'b1, 4'hF, 10'd7, 32'h2); step();
        chk("t3_rdw0_q0a", q0a, 32'h1);
        pa(1'b1, 4'h0, 10'd7, 32'h0); step();
        chk("t3_rdback_q0a", q0a, 32'h2);
        chk("t3_rdw1_first_q1a", q1a, 32'h1);
        step();
        chk("t3_rdw1_q1a", q1a, 32'h2);
        step();
        chk("t3_rdback_q1a", q1a, 32'h2);
        // collisions
        pa(1'b1, 4'hF, 10'd9, 32'hAAAAAAAA); pb(1'b1, 4'b0011, 10'd9, 32'h55555555); step();
        chk("t4_ww_c0", 32'(c0), 32'h1);
        chk("t4_ww_c1", 32'(c1), 32'h1);
        step();
        chk("t4_pulse_c0", 32'(c0), 32'h0);
        pb(1'b1, 4'h0, 10'd9, 32'h0); step();
        chk("t4_awins_q0b", q0b, 32'hAAAAAAAA);
        pa(1'b1, 4'hF, 10'd9, 32'h12345678); pb(1'b1, 4'h0, 10'd9, 32'h0); step();
        chk("t4_xrd_q0b", q0b, 32'hAAAAAAAA);
        chk("t4_xrd_c0", 32'(c0), 32'h1);
        pa(1'b1, 4'h0, 10'd9, 32'h0); pb(1'b1, 4'h0, 10'd9, 32'h0); step();
        chk("t4_rr_c0", 32'(c0), 32'h0);
        chk("t4_rr_q0a", q0a, 32'h12345678);
        chk("t4_rr_q0b", q0b, 32'h12345678);
        step(); step(); step();
        // three-stage pipeline and mid-flight reset
        pa(1'b1, 4'hF, 10'd1, 32'h101); step();
        pa(1'b1, 4'hF, 10'd2, 32'h202); step();
        pa(1'b1, 4'hF, 10'd3, 32'h303); step();
        pa(1'b1, 4'h0, 10'd1, 32'h0); step();
        pa(1'b1, 4'h0, 10'd2, 32'h0); step();
        chk("t5_pre_q1a", q1a, 32'h303);
        pa(1'b1, 4'h0, 10'd3, 32'h0); step();
        chk("t5_s1_v1a", 32'(v1a), 32'h1);
        chk("t5_s1_q1a", q1a, 32'h101);
        step();
        chk("t5_s2_v1a", 32'(v1a), 32'h1);
        chk("t5_s2_q1a", q1a, 32'h202);
        rst = 1'b1;
        #1;
        chk("t5_rst_v1a", 32'(v1a), 32'h0);
        chk("t5_rst_q1a", q1a, 32'h0);
        pa(1'b1, 4'hF, 10'd5, 32'hFFFFFFFF); step();
        chk("t5_no3rd_v1a", 32'(v1a), 32'h0);
        step();
        rst = 1'b0;
        pb(1'b1, 4'h0, 10'd5, 32'h0); step();
        chk("t5_rst_ignored_q0b", q0b, 32'h11BB33DD);
        // out-of-range addresses on the 1000-word instance
        pa(1'b1, 4'hF, 10'd0, 32'h0BADC0DE); pb(1'b1, 4'hF, 10'd999, 32'h99999999); step();
        pa(1'b1, 4'hF, 10'd1010, 32'hCAFEF00D); pb(1'b1, 4'hF, 10'd1010, 32'h11111111); step();
        chk("t6_nocoll_c0", 32'(c0), 32'h0);
        chk("t6_wr_v0a", 32'(v0a), 32'h1);
        chk("t6_wr_q0a", q0a, 32'h0);
        pa(1'b1, 4'h0, 10'd0, 32'h0); pb(1'b1, 4'h0, 10'd999, 32'h0); step();
        chk("t6_w0_q0a", q0a, 32'h0BADC0DE);
        chk("t6_w999_q0b", q0b, 32'h99999999);
        pa(1'b1, 4'h0, 10'd1010, 32'h0); step();
        chk("t6_oor_q0a", q0a, 32'h0);
        chk("t6_oor_v0a", 32'(v0a), 32'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
